hazard_scheduler: RTL and testbench

Pipeline hazard controller for the decode stage. Tracks in-flight register writes in a three-slot scoreboard (EX, MEM, WB) and drives the decode stage's `stall` and branch-operand forwarding selects. Squashes the fetched instruction on taken control flow. Sequences end-of-program drain to a halt. Sits beside the decode stage and consumes its decoded fields in the same cycle.

---
 rtl/hazard_scheduler_pkg.sv | 24 ++
 rtl/hazard_scheduler_scoreboard_slot.sv | 40 ++++
 rtl/hazard_scheduler.sv | 149 ++++++++++++++
 tb/tb_hazard_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scheduler_pkg
// Description : Shared word width, forwarding-select encodings and the
//               scoreboard slot record used by the decode hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scheduler_pkg;

    localparam int WORD = 32;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

endpackage : hazard_scheduler_pkg
`default_nettype wire

// File: rtl/hazard_scheduler_scoreboard_slot.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_slot
// Description : One registered {valid, dest, is_load} pipeline-stage record
//               with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_valid,
    input  logic [4:0] d_dest,
    input  logic       d_is_load,
    output logic       q_valid,
    output logic [4:0] q_dest,
    output logic       q_is_load
);

    logic       r_valid;
    logic [4:0] r_dest;
    logic       r_is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_dest    <= 5'd0;
            r_is_load <= 1'b0;
        end else begin
            r_valid   <= d_valid;
            r_dest    <= d_dest;
            r_is_load <= d_is_load;
        end
    end

    assign q_valid   = r_valid;
    assign q_dest    = r_dest;
    assign q_is_load = r_is_load;

endmodule : scoreboard_slot
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scheduler
// Description : Decode-stage hazard control: EX/MEM/WB write scoreboard,
//               load-use stall, branch operand forwarding, flush and drain.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic             id_is_branch,
    input  logic             id_ctl_taken,
    input  logic             id_terminate,
    output logic             stall,
    output logic             flush_if,
    output logic [1:0]       branch_a1_sel,
    output logic [1:0]       branch_a2_sel,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int C_DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic [1:0]       r_state;
    logic [C_DW-1:0]  r_drain;
    logic [CNT_W-1:0] r_stall_count;

    slot_t w_ex_in;
    slot_t w_ex;
    slot_t w_mem;
    slot_t w_wb;

    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem, w_rs_wb, w_rt_wb;
    logic w_load_use;
    logic w_branch_stall;
    logic w_stall;
    logic [1:0] w_a1_sel;
    logic [1:0] w_a2_sel;

    function automatic logic hit(input logic [4:0] src, input slot_t s);
        return s.valid && (src != 5'd0) && (src == s.dest);
    endfunction

    // Stalled decode is held in IF/ID, so EX must receive a bubble.
    assign w_ex_in.valid   = id_wb_en && (id_dest != 5'd0) && !w_stall;
    assign w_ex_in.dest    = id_dest;
    assign w_ex_in.is_load = id_mem_r;

    scoreboard_slot u_slot_ex (
        .clk(clk), .rst(rst),
        .d_valid(w_ex_in.valid), .d_dest(w_ex_in.dest), .d_is_load(w_ex_in.is_load),
        .q_valid(w_ex.valid), .q_dest(w_ex.dest), .q_is_load(w_ex.is_load)
    );

    scoreboard_slot u_slot_mem (
        .clk(clk), .rst(rst),
        .d_valid(w_ex.valid), .d_dest(w_ex.dest), .d_is_load(w_ex.is_load),
        .q_valid(w_mem.valid), .q_dest(w_mem.dest), .q_is_load(w_mem.is_load)
    );

    scoreboard_slot u_slot_wb (
        .clk(clk), .rst(rst),
        .d_valid(w_mem.valid), .d_dest(w_mem.dest), .d_is_load(w_mem.is_load),
        .q_valid(w_wb.valid), .q_dest(w_wb.dest), .q_is_load(w_wb.is_load)
    );

    assign w_rs_ex  = hit(id_rs, w_ex);
    assign w_rt_ex  = hit(id_rt, w_ex);
    assign w_rs_mem = hit(id_rs, w_mem);
    assign w_rt_mem = hit(id_rt, w_mem);
    assign w_rs_wb  = hit(id_rs, w_wb);
    assign w_rt_wb  = hit(id_rt, w_wb);

    assign w_load_use     = (w_rs_ex || w_rt_ex) && w_ex.is_load;
    assign w_branch_stall = id_is_branch && w_load_use;
    assign w_stall        = w_load_use || w_branch_stall || (r_state != ST_RUN);

    // A load in EX has no data yet, so it falls through to the older slots.
    always_comb begin
        w_a1_sel = FWD_RF;
        w_a2_sel = FWD_RF;
        if (id_is_branch) begin
            if (w_rs_ex && !w_ex.is_load) w_a1_sel = FWD_EX;
            else if (w_rs_mem)            w_a1_sel = FWD_MEM;
            else if (w_rs_wb)             w_a1_sel = FWD_WB;

            if (w_rt_ex && !w_ex.is_load) w_a2_sel = FWD_EX;
            else if (w_rt_mem)            w_a2_sel = FWD_MEM;
            else if (w_rt_wb)             w_a2_sel = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (id_terminate && !w_stall) begin
                        r_state <= (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
                        r_drain <= C_DW'(DRAIN_CYCLES);
                    end
                end
                // Halt lands on the cycle after the last bubble.
                ST_DRAIN: begin
                    if (r_drain <= C_DW'(1)) begin
                        r_state <= ST_HALT;
                        r_drain <= '0;
                    end else begin
                        r_drain <= r_drain - C_DW'(1);
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign stall         = w_stall;
    assign flush_if      = id_ctl_taken && !w_stall && (r_state == ST_RUN);
    assign branch_a1_sel = w_a1_sel;
    assign branch_a2_sel = w_a2_sel;
    assign halt          = (r_state == ST_HALT);
    assign stall_count   = r_stall_count;

endmodule : hazard_scheduler
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scheduler
// Description : Directed self-checking bench for hazard_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_wb_en, id_mem_r, id_is_branch, id_ctl_taken, id_terminate;
    logic        stall, flush_if, halt;
    logic [1:0]  branch_a1_sel, branch_a2_sel;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_is_branch(id_is_branch),
        .id_ctl_taken(id_ctl_taken), .id_terminate(id_terminate),
        .stall(stall), .flush_if(flush_if),
        .branch_a1_sel(branch_a1_sel), .branch_a2_sel(branch_a2_sel),
        .halt(halt), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; checks follow 1 ns later.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                         input logic wb, input logic mr, input logic br,
                         input logic tk, input logic tm);
        id_rs = rs; id_rt = rt; id_dest = dest;
        id_wb_en = wb; id_mem_r = mr; id_is_branch = br;
        id_ctl_taken = tk; id_terminate = tm;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush_if, 0);
        chk("rst_halt", halt, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_a1", branch_a1_sel, 0);

        // lw $8 ; add $9,$8,$10
        drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_lw_nostall", stall, 0);
        tick();
        drive(5'd8, 5'd10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_stall_clear", stall, 0);
        chk("lu_cnt", stall_count, 1);
        tick();
        nops(3);

        // lw $7 ; use via rt
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_stall", stall, 1);
        tick();
        chk("lu_rt_clear", stall, 0);
        chk("lu_rt_cnt", stall_count, 2);
        tick();
        nops(3);

        // add $4 ; add $3 ; beq $3,$4 -> EX / MEM
        drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nobranch_a1", branch_a1_sel, 0);
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("bf_ex_stall", stall, 0);
        chk("bf_ex_a1", branch_a1_sel, 1);
        chk("bf_mem_a2", branch_a2_sel, 2);
        chk("bf_flush", flush_if, 1);
        tick();
        nops(3);

        // add $3 ; beq $3,$4 -> a1 EX, a2 regfile
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bf0_a1", branch_a1_sel, 1);
        chk("bf0_a2", branch_a2_sel, 0);
        tick();
        nops(3);

        // add $3 ; nop ; beq -> MEM
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        nops(1);
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bf1_a1", branch_a1_sel, 2);
        tick();
        nops(3);

        // add $3 ; nop ; nop ; beq -> WB
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        nops(2);
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bf2_a1", branch_a1_sel, 3);
        tick();
        nops(3);

        // lw $5 ; beq $5,$0 taken
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("bl_stall", stall, 1);
        chk("bl_noflush", flush_if, 0);
        tick();
        chk("bl_stall_clear", stall, 0);
        chk("bl_a1", branch_a1_sel, 2);
        chk("bl_flush", flush_if, 1);
        chk("bl_cnt", stall_count, 3);
        tick();
        nops(3);

        // add $0 ; beq $0,$0
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("z_stall", stall, 0);
        chk("z_a1", branch_a1_sel, 0);
        chk("z_a2", branch_a2_sel, 0);
        tick();
        nops(3);

        // Terminate blocked by a load-use stall, then accepted (cycle T)
        drive(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tm_blocked_stall", stall, 1);
        tick();
        chk("tm_T_stall", stall, 0);
        chk("tm_T_halt", halt, 0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tm_T1_stall", stall, 1);
        chk("tm_T1_noflush", flush_if, 0);
        chk("tm_T1_halt", halt, 0);
        tick();
        chk("tm_T2_halt", halt, 0);
        tick();
        chk("tm_T3_halt", halt, 0);
        chk("tm_T3_stall", stall, 1);
        tick();
        chk("tm_T4_halt", halt, 1);
        chk("tm_T4_stall", stall, 1);
        chk("tm_T4_cnt", stall_count, 7);
        tick();
        chk("tm_T5_halt", halt, 1);
        chk("tm_T5_cnt", stall_count, 8);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst2_halt", halt, 0);
        chk("rst2_cnt", stall_count, 0);

        // Terminate at T, reset during T+2
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("md_T1_stall", stall, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("md_rst_stall", stall, 0);
        chk("md_rst_halt", halt, 0);
        chk("md_rst_cnt", stall_count, 0);
        chk("md_rst_flush", flush_if, 1);
        nops(4);
        chk("md_after_halt", halt, 0);
        chk("md_after_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_scheduler
`default_nettype wire
